crc_frame_ctrl: RTL and testbench
=================================

// Module: crc_frame_ctrl
// PURPOSE
//  Frame sequencer for one generic_crc engine. Accepts a word stream over valid/ready with a
//  last marker, clears the engine before each frame, drives crc_en/data per accepted word, then
//  captures the finished checksum and presents it with word count on a valid/ready result port.
//  Sits between the packet source and the CRC engine; one frame in flight at a time.
// PARAMETERS
//  DATAWIDTH  8     width of each stream word; must match the engine's DATAWIDTH
//  POLYWIDTH  8     checksum width; must match the engine's POLYWIDTH
//  MAX_WORDS  1024  longest legal frame in words (>=1); LENW = $clog2(MAX_WORDS+1)
// PORTS
//  clk            in   1          single clock, all logic posedge
//  rst            in   1          synchronous, active-high reset
//  s_valid_i      in   1          input word valid
//  s_data_i       in   DATAWIDTH  input word
//  s_last_i       in   1          final word of frame, qualified by s_valid_i
//  s_ready_o      out  1          controller accepts word this cycle
//  crc_rst_o      out  1          clear to engine rst
//  crc_en_o       out  1          engine crc_en
//  crc_data_o     out  DATAWIDTH  engine data_i
//  crc_sum_i      in   POLYWIDTH  engine checksum_o; registered, updates 1 cycle after crc_en_o
//  m_valid_o      out  1          result valid
//  m_ready_i      in   1          result consumed
//  m_checksum_o   out  POLYWIDTH  captured checksum
//  m_len_o        out  LENW       words in frame (1..MAX_WORDS)
//  m_err_o        out  1          frame truncated at MAX_WORDS (no s_last_i seen)
//  busy_o         out  1          high in every state except IDLE
// BEHAVIOUR
//  FSM: IDLE -> CLEAR -> RUN -> WAIT -> DONE -> IDLE.
//  - IDLE : s_ready_o=0. If s_valid_i=1 go to CLEAR; word is held by source, not consumed.
//  - CLEAR: one cycle, crc_rst_o=1, len counter <= 0, err <= 0. Next: RUN.
//  - RUN  : s_ready_o=1. Accept = s_valid_i & s_ready_o -> crc_en_o=1, crc_data_o=s_data_i,
//           len++ (combinational pass-through, engine samples same edge). s_valid_i=0 -> stall,
//           crc_en_o=0, stay in RUN indefinitely.
//           Accept with s_last_i=1 -> WAIT. Accept making len==MAX_WORDS with s_last_i=0 ->
//           err <= 1, WAIT; following words are not accepted until next frame.
//  - WAIT : one cycle, s_ready_o=0; crc_sum_i now includes last word; capture into
//           m_checksum_o, len into m_len_o, err into m_err_o. Next: DONE.
//  - DONE : m_valid_o=1, m_* stable. m_ready_i=1 -> IDLE (m_valid_o falls next cycle).
//  Latency: last-word accept at cycle t -> m_valid_o=1 at t+2. Min frame period 5 cycles
//  (CLEAR+RUN(1 word)+WAIT+DONE+IDLE) with m_ready_i held high.
//  crc_rst_o = rst | (state==CLEAR); crc_en_o forced 0 outside RUN and during rst.
//  crc_data_o = s_data_i always (only meaningful with crc_en_o).
//  m_valid_o is never dropped without m_ready_i; m_* change only in WAIT.
//  Reset (any state, incl. mid-frame): state=IDLE, s_ready_o=0, crc_en_o=0, crc_rst_o=1,
//   m_valid_o=0, m_checksum_o=0, m_len_o=0, m_err_o=0, busy_o=0; partial frame discarded.
//  Width rules: len counter LENW bits, saturates by construction at MAX_WORDS (never wraps).
//  No FINAL_XOR/reflect handling here; the engine owns all checksum arithmetic.
// TESTING
//  1 CRC-8 poly 0x07: frame 0x31..0x39 ("123456789"), last on 0x39 -> m_checksum=0xF4, len=9,
//    err=0, m_valid 2 cycles after last accept.
//  2 Single-word frame 0x00 then 0x01 back-to-back, m_ready=1 -> sums 0x00 then 0x07, engine
//    cleared between frames (crc_rst_o pulse seen once per frame).
//  3 Random s_valid gaps and m_ready held 0 for 20 cycles -> checksum matches model, m_* stable,
//    s_ready_o=0 throughout DONE.
//  4 MAX_WORDS=4, 6 words without last -> len=4, err=1, checksum over first 4 words only.
//  5 rst asserted mid-RUN after 3 words, then full frame "123456789" -> outputs all 0 during rst,
//    next result 0xF4 (no residue from aborted frame).

Source files
------------

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: sequences one CRC engine per frame and presents checksum, length and error
module crc_frame_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int POLYWIDTH = 8,
  parameter int MAX_WORDS = 1024,
  localparam int LENW = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid_i,
  input  logic [DATAWIDTH-1:0] s_data_i,
  input  logic                 s_last_i,
  output logic                 s_ready_o,
  output logic                 crc_rst_o,
  output logic                 crc_en_o,
  output logic [DATAWIDTH-1:0] crc_data_o,
  input  logic [POLYWIDTH-1:0] crc_sum_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [POLYWIDTH-1:0] m_checksum_o,
  output logic [LENW-1:0]      m_len_o,
  output logic                 m_err_o,
  output logic                 busy_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [LENW-1:0] len_q, len_d, m_len_q;
  logic err_q, err_d, m_err_q;
  logic [POLYWIDTH-1:0] m_checksum_q;
  logic at_max;
  assign at_max = len_q == LENW'(MAX_WORDS - 1);
  assign crc_data_o = s_data_i;
  assign m_checksum_o = m_checksum_q;
  assign m_len_o = m_len_q;
  assign m_err_o = m_err_q;
  // state register
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end
  // next state: the word that wakes IDLE stays with the source until RUN accepts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = s_valid_i ? CLEAR : IDLE;
      CLEAR:   state_d = RUN;
      RUN:     state_d = (crc_en_o && (s_last_i || at_max)) ? WAIT : RUN;
      WAIT:    state_d = DONE;
      DONE:    state_d = m_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // outputs: rst masks all handshakes so a stale state cannot leak during reset
  always_comb begin
    s_ready_o = !rst && state_q == RUN;
    crc_en_o  = s_ready_o && s_valid_i;
    crc_rst_o = rst || state_q == CLEAR;
    m_valid_o = !rst && state_q == DONE;
    busy_o    = !rst && state_q != IDLE;
  end
  // frame length and truncation flag; len stops at MAX_WORDS because RUN exits there
  always_comb begin
    len_d = state_q == CLEAR ? '0 : crc_en_o ? len_q + LENW'(1) : len_q;
    err_d = state_q == CLEAR ? 1'b0 : (crc_en_o && at_max && !s_last_i) ? 1'b1 : err_q;
  end
  // counters and result capture; engine sum includes the last word by WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      err_q <= 1'b0;
      m_checksum_q <= '0;
      m_len_q <= '0;
      m_err_q <= 1'b0;
    end else begin
      len_q <= len_d;
      err_q <= err_d;
      if (state_q == WAIT) begin
        m_checksum_q <= crc_sum_i;
        m_len_q <= len_q;
        m_err_q <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl: randomized checks of the frame controller driving a CRC-8 (0x07) engine model
module tb_crc_frame_ctrl;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_last = 0, m_ready = 0;
  logic [7:0] s_data = 0;
  logic s_ready, crc_rst, crc_en, m_valid, m_err, busy;
  logic [7:0] crc_data, crc_sum, m_sum;
  logic [10:0] m_len;
  logic s4_valid = 0, s4_last = 0, m4_ready = 0;
  logic [7:0] s4_data = 0;
  logic s4_ready, crc4_rst, crc4_en, m4_valid, m4_err, busy4;
  logic [7:0] crc4_data, crc4_sum, m4_sum;
  logic [2:0] m4_len;
  int pass = 0, total = 0, clr_cnt = 0;
  typedef struct {logic [7:0] sum; logic [10:0] len; logic err;} res_t;
  res_t rq[$];
  logic [7:0] golden[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  always #5 clk = ~clk;

  crc_frame_ctrl #(.DATAWIDTH(8), .POLYWIDTH(8), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
    .s_ready_o(s_ready), .crc_rst_o(crc_rst), .crc_en_o(crc_en), .crc_data_o(crc_data),
    .crc_sum_i(crc_sum), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_checksum_o(m_sum),
    .m_len_o(m_len), .m_err_o(m_err), .busy_o(busy));

  crc_frame_ctrl #(.DATAWIDTH(8), .POLYWIDTH(8), .MAX_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid_i(s4_valid), .s_data_i(s4_data), .s_last_i(s4_last),
    .s_ready_o(s4_ready), .crc_rst_o(crc4_rst), .crc_en_o(crc4_en), .crc_data_o(crc4_data),
    .crc_sum_i(crc4_sum), .m_valid_o(m4_valid), .m_ready_i(m4_ready), .m_checksum_o(m4_sum),
    .m_len_o(m4_len), .m_err_o(m4_err), .busy_o(busy4));

  function automatic logic [7:0] eng_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    foreach (msg[i])
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return r;
  endfunction

  always @(posedge clk) begin
    crc_sum <= crc_rst ? 8'h00 : crc_en ? eng_step(crc_sum, crc_data) : crc_sum;
    crc4_sum <= crc4_rst ? 8'h00 : crc4_en ? eng_step(crc4_sum, crc4_data) : crc4_sum;
    if (!rst && crc_rst) clr_cnt <= clr_cnt + 1;
    if (!rst && m_valid && m_ready) rq.push_back('{m_sum, m_len, m_err});
  end

  task automatic send(input logic [7:0] w[$], input int gap);
    int i = 0, n = 0;
    while (i < w.size() && n < 500) begin
      @(negedge clk); n++;
      if (int'($urandom_range(99)) < gap) s_valid = 0;
      else begin s_valid = 1; s_data = w[i]; s_last = (i == w.size() - 1); end
      #1;
      if (s_valid && s_ready) i++;
    end
    total++; if (i != w.size()) $display("FAIL send_timeout accepted %0d want %0d", i, w.size()); else pass++;
    @(negedge clk); s_valid = 0; s_last = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    total++; if (!m_valid) $display("FAIL wait_valid timeout"); else pass++;
  endtask

  task automatic ack();
    m_ready = 1; @(negedge clk); m_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; s_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (s_ready !== 0) $display("FAIL rst_s_ready got %b want 0", s_ready); else pass++;
    total++; if (crc_en !== 0) $display("FAIL rst_crc_en got %b want 0", crc_en); else pass++;
    total++; if (crc_rst !== 1) $display("FAIL rst_crc_rst got %b want 1", crc_rst); else pass++;
    total++; if (m_valid !== 0) $display("FAIL rst_m_valid got %b want 0", m_valid); else pass++;
    total++; if (busy !== 0) $display("FAIL rst_busy got %b want 0", busy); else pass++;
    total++; if (m_sum !== 0 || m_len !== 0 || m_err !== 0)
      $display("FAIL rst_m_fields got %h/%0d/%b want 0/0/0", m_sum, m_len, m_err); else pass++;
    s_valid = 0; rst = 0;
    @(negedge clk);
  endtask

  task automatic test_golden();
    rq.delete(); m_ready = 0;
    send(golden, 0);
    total++; if (m_valid !== 0 || s_ready !== 0) $display("FAIL golden_wait got v=%b r=%b want 0/0", m_valid, s_ready); else pass++;
    @(negedge clk);
    total++; if (m_valid !== 1) $display("FAIL golden_latency got %b want 1", m_valid); else pass++;
    total++; if (m_sum !== 8'hF4) $display("FAIL golden_sum got %h want f4", m_sum); else pass++;
    total++; if (m_len !== 11'd9 || m_err !== 0) $display("FAIL golden_len got %0d/%b want 9/0", m_len, m_err); else pass++;
    ack();
    total++; if (m_valid !== 0 || rq.size() != 1) $display("FAIL golden_ack got v=%b n=%0d want 0/1", m_valid, rq.size()); else pass++;
  endtask

  task automatic test_back_to_back();
    int c0, n;
    logic [7:0] w0[$], w1[$];
    w0 = '{8'h00}; w1 = '{8'h01};
    rq.delete(); c0 = clr_cnt; m_ready = 1; n = 0;
    send(w0, 0);
    send(w1, 0);
    while (rq.size() < 2 && n < 50) begin @(negedge clk); n++; end
    m_ready = 0;
    total++; if (rq.size() != 2) $display("FAIL b2b_count got %0d want 2", rq.size()); else begin
      pass++;
      total++; if (rq[0].sum !== 8'h00 || rq[0].len !== 11'd1) $display("FAIL b2b_first got %h/%0d want 00/1", rq[0].sum, rq[0].len); else pass++;
      total++; if (rq[1].sum !== 8'h07 || rq[1].len !== 11'd1) $display("FAIL b2b_second got %h/%0d want 07/1", rq[1].sum, rq[1].len); else pass++;
    end
    total++; if (clr_cnt - c0 != 2) $display("FAIL b2b_clears got %0d want 2", clr_cnt - c0); else pass++;
  endtask

  task automatic test_random_gaps();
    repeat (3) begin
      logic [7:0] w[$];
      logic [7:0] exp;
      logic stable;
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) w.push_back(8'($urandom));
      exp = ref_crc(w); stable = 1; rq.delete();
      send(w, 40);
      wait_valid();
      total++; if (m_sum !== exp || m_len !== 11'(n) || m_err !== 0)
        $display("FAIL rand_result got %h/%0d/%b want %h/%0d/0", m_sum, m_len, m_err, exp, n); else pass++;
      for (int c = 0; c < 20; c++) begin
        s_valid = 1; s_data = 8'($urandom); s_last = 1'($urandom_range(1));
        @(negedge clk); #1;
        if (m_valid !== 1 || m_sum !== exp || m_len !== 11'(n) || s_ready !== 0 || crc_en !== 0) stable = 0;
      end
      total++; if (stable !== 1) $display("FAIL rand_hold got unstable want stable"); else pass++;
      s_valid = 0; s_last = 0;
      ack();
      total++; if (rq.size() != 1) $display("FAIL rand_consume got %0d want 1", rq.size()); else pass++;
    end
  endtask

  task automatic test_truncate();
    logic [7:0] w[$];
    int acc = 0, n = 0;
    for (int i = 0; i < 6; i++) w.push_back(8'($urandom));
    s4_last = 0;
    while (n < 100 && acc < 6) begin
      @(negedge clk); n++;
      s4_valid = 1; s4_data = w[acc];
      #1;
      if (m4_valid) break;
      if (s4_valid && s4_ready) acc++;
    end
    total++; if (m4_valid !== 1 || acc != 4) $display("FAIL trunc_accepts got v=%b n=%0d want 1/4", m4_valid, acc); else pass++;
    total++; if (m4_len !== 3'd4 || m4_err !== 1) $display("FAIL trunc_len got %0d/%b want 4/1", m4_len, m4_err); else pass++;
    w = w[0:3];
    total++; if (m4_sum !== ref_crc(w)) $display("FAIL trunc_sum got %h want %h", m4_sum, ref_crc(w)); else pass++;
    total++; if (s4_ready !== 0) $display("FAIL trunc_ready got %b want 0", s4_ready); else pass++;
    s4_valid = 0; m4_ready = 1; @(negedge clk); m4_ready = 0;
  endtask

  task automatic test_reset_midrun();
    int acc = 0, n = 0;
    m_ready = 0; s_last = 0;
    while (acc < 3 && n < 50) begin
      @(negedge clk); n++;
      s_valid = 1; s_data = golden[acc];
      #1;
      if (s_ready) acc++;
    end
    total++; if (acc != 3 || busy !== 1) $display("FAIL mid_setup got %0d/%b want 3/1", acc, busy); else pass++;
    @(negedge clk); rst = 1; s_data = golden[3]; #1;
    total++; if (s_ready !== 0 || crc_en !== 0 || busy !== 0 || m_valid !== 0)
      $display("FAIL mid_rst_ctrl got r=%b e=%b b=%b v=%b want 0", s_ready, crc_en, busy, m_valid); else pass++;
    total++; if (crc_rst !== 1) $display("FAIL mid_rst_clear got %b want 1", crc_rst); else pass++;
    @(negedge clk); #1;
    total++; if (m_sum !== 0 || m_len !== 0 || m_err !== 0 || crc_sum !== 0)
      $display("FAIL mid_rst_regs got %h/%0d/%b/%h want 0", m_sum, m_len, m_err, crc_sum); else pass++;
    rst = 0; s_valid = 0;
    send(golden, 20);
    wait_valid();
    total++; if (m_sum !== 8'hF4 || m_len !== 11'd9 || m_err !== 0)
      $display("FAIL mid_after got %h/%0d/%b want f4/9/0", m_sum, m_len, m_err); else pass++;
    ack();
  endtask

  initial begin
    test_reset();
    test_golden();
    test_back_to_back();
    test_random_gaps();
    test_truncate();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
